// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and pipeline-control decode for the MEM->WB register.
package mem_wb_pipe_pkg;

  // Bit positions of the ctrl-unit stall vector.
  localparam int STALL_MEM_BIT = 0;
  localparam int STALL_WB_BIT  = 1;

  // Register $0 doubles as the NOP destination.
  localparam int NOP_REG_ADDR = 0;

  localparam logic WE_ENABLE  = 1'b1;
  localparam logic WE_DISABLE = 1'b0;

  // What every flop in the stage does on the coming edge.
  typedef enum logic [1:0] {
    OP_CAPTURE = 2'd0,
    OP_HOLD    = 2'd1,
    OP_BUBBLE  = 2'd2,
    OP_FLUSH   = 2'd3
  } pipe_op_e;

  // Priority flush > bubble > hold > capture; stall_wb without stall_mem is
  // not a legal ctrl pattern and falls through to capture.
  function automatic pipe_op_e decode_op(input logic flush, input logic [1:0] stall);
    if (flush) return OP_FLUSH;
    if (stall[STALL_MEM_BIT] && !stall[STALL_WB_BIT]) return OP_BUBBLE;
    if (stall[STALL_MEM_BIT] && stall[STALL_WB_BIT]) return OP_HOLD;
    return OP_CAPTURE;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_lane.sv
// One GPR write lane of the MEM->WB register.
module mem_wb_pipe_lane
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  pipe_op_e          op,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] wd_d,    wd_q;
  logic              wreg_d,  wreg_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;

  // Next-state select: clear on flush/bubble, keep on hold, load on capture.
  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    case (op)
      OP_FLUSH, OP_BUBBLE: begin
        valid_d = 1'b0;
        wd_d    = ADDR_W'(NOP_REG_ADDR);
        wreg_d  = WE_DISABLE;
        wdata_d = '0;
      end
      OP_CAPTURE: begin
        valid_d = valid_i;
        wd_d    = wd_i;
        wreg_d  = wreg_i;
        wdata_d = wdata_i;
      end
      default: ;
    endcase
  end

  // Lane registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      wd_q    <= ADDR_W'(NOP_REG_ADDR);
      wreg_q  <= WE_DISABLE;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign valid_o = valid_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: LANES GPR write lanes, shared HI/LO write,
// $0/WAW write qualification and a retired-instruction counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    stall_mem,
  input  logic                    stall_wb,
  input  logic [LANES-1:0]        mem_valid,
  input  logic [LANES*ADDR_W-1:0] mem_wd,
  input  logic [LANES-1:0]        mem_wreg,
  input  logic [LANES*DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  input  logic                    mem_whilo,
  output logic [LANES-1:0]        wb_valid,
  output logic [LANES*ADDR_W-1:0] wb_wd,
  output logic [LANES-1:0]        wb_wreg,
  output logic [LANES*DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo,
  output logic                    wb_whilo,
  output logic [CNT_W-1:0]        retire_cnt
);

  pipe_op_e          op;
  logic [1:0]        stall_vec;
  logic [LANES-1:0]  wreg_qual;
  logic [LANES-1:0]  wreg_final;
  logic [CNT_W-1:0]  valid_cnt;

  logic [DATA_W-1:0] hi_d, hi_q, lo_d, lo_q;
  logic              whilo_d, whilo_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Stage operation from the ctrl-unit stall vector.
  always_comb begin
    stall_vec                = '0;
    stall_vec[STALL_MEM_BIT] = stall_mem;
    stall_vec[STALL_WB_BIT]  = stall_wb;
    op                       = decode_op(flush, stall_vec);
  end

  // Write qualification: drop $0 writes, then let the youngest lane win a WAW.
  always_comb begin
    wreg_qual = '0;
    for (int k = 0; k < LANES; k++) begin
      wreg_qual[k] = mem_valid[k] & mem_wreg[k] &
                     (mem_wd[k*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR));
    end
    wreg_final = wreg_qual;
    for (int k = 0; k < LANES; k++) begin
      for (int j = k + 1; j < LANES; j++) begin
        if (wreg_qual[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[k*ADDR_W +: ADDR_W]))
          wreg_final[k] = WE_DISABLE;
      end
    end
  end

  // Number of real instructions in the incoming bundle.
  always_comb begin
    valid_cnt = '0;
    for (int k = 0; k < LANES; k++) valid_cnt = valid_cnt + CNT_W'(mem_valid[k]);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_wb_pipe_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .valid_i (mem_valid[g]),
      .wd_i    (mem_wd[g*ADDR_W +: ADDR_W]),
      .wreg_i  (wreg_final[g]),
      .wdata_i (mem_wdata[g*DATA_W +: DATA_W]),
      .valid_o (wb_valid[g]),
      .wd_o    (wb_wd[g*ADDR_W +: ADDR_W]),
      .wreg_o  (wb_wreg[g]),
      .wdata_o (wb_wdata[g*DATA_W +: DATA_W])
    );
  end

  // HI/LO and counter next state; the counter moves only on capture.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    cnt_d   = cnt_q;
    case (op)
      OP_FLUSH, OP_BUBBLE: begin
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = WE_DISABLE;
      end
      OP_CAPTURE: begin
        hi_d    = mem_hi;
        lo_d    = mem_lo;
        whilo_d = mem_whilo & (|mem_valid);
        cnt_d   = cnt_q + valid_cnt;
      end
      default: ;
    endcase
  end

  // Shared registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= WE_DISABLE;
      cnt_q   <= '0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_hi      = hi_q;
  assign wb_lo      = lo_q;
  assign wb_whilo   = whilo_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed scoreboard bench for mem_wb_pipe (2 lanes, 4-bit retire counter).
module tb_mem_wb_pipe;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush, stall_mem, stall_wb;
  logic [LANES-1:0]        mem_valid;
  logic [LANES*ADDR_W-1:0] mem_wd;
  logic [LANES-1:0]        mem_wreg;
  logic [LANES*DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0]       mem_hi, mem_lo;
  logic                    mem_whilo;
  logic [LANES-1:0]        wb_valid;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0]       wb_hi, wb_lo;
  logic                    wb_whilo;
  logic [CNT_W-1:0]        retire_cnt;

  always #5 clk = ~clk;

  mem_wb_pipe #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [LANES-1:0]        valid;
    logic [LANES*ADDR_W-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]       hi;
    logic [DATA_W-1:0]       lo;
    logic                    whilo;
    logic [CNT_W-1:0]        cnt;
  } exp_t;

  exp_t model;
  exp_t zero_e;
  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vecs++;
    assert (obs === expv)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 128'(wb_valid),   128'(e.valid));
    chk({tag, ".wd"},    128'(wb_wd),      128'(e.wd));
    chk({tag, ".wreg"},  128'(wb_wreg),    128'(e.wreg));
    chk({tag, ".wdata"}, 128'(wb_wdata),   128'(e.wdata));
    chk({tag, ".hi"},    128'(wb_hi),      128'(e.hi));
    chk({tag, ".lo"},    128'(wb_lo),      128'(e.lo));
    chk({tag, ".whilo"}, 128'(wb_whilo),   128'(e.whilo));
    chk({tag, ".cnt"},   128'(retire_cnt), 128'(e.cnt));
  endtask

  // Reference behaviour of one clock edge, applied to the bench model.
  task automatic model_edge;
    logic [LANES-1:0] q;
    logic [LANES-1:0] w;
    if (flush || (stall_mem && !stall_wb)) begin
      model.valid = '0; model.wd = '0; model.wreg = '0; model.wdata = '0;
      model.hi = '0; model.lo = '0; model.whilo = 1'b0;
    end else if (stall_mem && stall_wb) begin
      // hold everything
    end else begin
      for (int k = 0; k < LANES; k++)
        q[k] = mem_valid[k] && mem_wreg[k] && (mem_wd[k*ADDR_W +: ADDR_W] != 0);
      w = q;
      for (int k = 0; k < LANES; k++)
        for (int j = k + 1; j < LANES; j++)
          if (q[j] && mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[k*ADDR_W +: ADDR_W]) w[k] = 1'b0;
      model.valid = mem_valid; model.wd = mem_wd; model.wreg = w; model.wdata = mem_wdata;
      model.hi = mem_hi; model.lo = mem_lo; model.whilo = mem_whilo && (mem_valid != 0);
      for (int k = 0; k < LANES; k++) model.cnt = model.cnt + CNT_W'(mem_valid[k]);
    end
  endtask

  // Drive one bundle, push its expectation, clock it and compare.
  task automatic step(input string tag, input logic fl, input logic sm, input logic sw,
                      input logic [1:0] v, input logic [ADDR_W-1:0] wd1, input logic [ADDR_W-1:0] wd0,
                      input logic [1:0] wr, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d0,
                      input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo, input logic whl);
    exp_t e;
    flush = fl; stall_mem = sm; stall_wb = sw;
    mem_valid = v; mem_wd = {wd1, wd0}; mem_wreg = wr; mem_wdata = {d1, d0};
    mem_hi = hi; mem_lo = lo; mem_whilo = whl;
    model_edge();
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vecs++; errs++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_e = '{valid: '0, wd: '0, wreg: '0, wdata: '0, hi: '0, lo: '0, whilo: 1'b0, cnt: '0};
    model  = zero_e;
    rst = 1'b0; flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    mem_valid = '0; mem_wd = '0; mem_wreg = '0; mem_wdata = '0;
    mem_hi = '0; mem_lo = '0; mem_whilo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", zero_e);
    rst = 1'b1;

    // Basic capture: lane1=5/AA, lane0=3/BB.
    step("cap", 0, 0, 0, 2'b11, 5'd5, 5'd3, 2'b11, 32'hAA, 32'hBB, 32'h1111, 32'h2222, 1'b1);
    chk("cap.wreg_dir", 128'(wb_wreg), 128'(2'b11));
    chk("cap.cnt_dir",  128'(retire_cnt), 128'(4'd2));
    // WAW: both lanes target r7, older lane0 squashed.
    step("waw", 0, 0, 0, 2'b11, 5'd7, 5'd7, 2'b11, 32'hC1, 32'hC0, 32'h0, 32'h0, 1'b0);
    chk("waw.wreg_dir", 128'(wb_wreg), 128'(2'b10));
    // $0 on lane0 suppressed, lane1 writes r4.
    step("zero", 0, 0, 0, 2'b11, 5'd4, 5'd0, 2'b11, 32'hD1, 32'hD0, 32'h0, 32'h0, 1'b0);
    chk("zero.wreg_dir", 128'(wb_wreg), 128'(2'b10));
    // Invalid lane with wreg set passes data but never writes.
    step("inv", 0, 0, 0, 2'b10, 5'd9, 5'd8, 2'b11, 32'hE1, 32'hE0, 32'h5, 32'h6, 1'b1);
    // Hold for three clocks with different inputs present.
    for (int i = 0; i < 3; i++)
      step("hold", 0, 1, 1, 2'b11, 5'd1, 5'd2, 2'b11, 32'hF1, 32'hF0, 32'h7, 32'h8, 1'b1);
    chk("hold.cnt_dir", 128'(retire_cnt), 128'(4'd7));
    // Bubble.
    step("bub", 0, 1, 0, 2'b11, 5'd1, 5'd2, 2'b11, 32'hF1, 32'hF0, 32'h7, 32'h8, 1'b1);
    chk("bub.valid_dir", 128'(wb_valid), 128'(2'b00));
    // Refill, then flush beats capture.
    step("refill", 0, 0, 0, 2'b01, 5'd6, 5'd6, 2'b01, 32'h61, 32'h60, 32'h9, 32'hA, 1'b1);
    step("flush", 1, 0, 0, 2'b11, 5'd10, 5'd11, 2'b11, 32'h71, 32'h70, 32'hB, 32'hC, 1'b1);
    chk("flush.cnt_dir", 128'(retire_cnt), 128'(4'd8));
    // Illegal stall_wb-only is a capture.
    step("swonly", 0, 0, 1, 2'b11, 5'd12, 5'd13, 2'b11, 32'h81, 32'h80, 32'h0, 32'h0, 1'b0);
    // Climb to 15, then wrap.
    for (int i = 0; i < 2; i++)
      step("climb", 0, 0, 0, 2'b11, 5'd14, 5'd15, 2'b01, 32'h91, 32'h90, 32'h0, 32'h0, 1'b0);
    step("c15", 0, 0, 0, 2'b01, 5'd16, 5'd17, 2'b01, 32'hA1, 32'hA0, 32'h0, 32'h0, 1'b0);
    chk("c15.cnt_dir", 128'(retire_cnt), 128'(4'd15));
    step("wrap", 0, 0, 0, 2'b01, 5'd18, 5'd19, 2'b01, 32'hB1, 32'hB0, 32'h0, 32'h0, 1'b0);
    chk("wrap.cnt_dir", 128'(retire_cnt), 128'(4'd0));
    // HI/LO write with no valid lane is dropped; with a valid lane it goes.
    step("hilo0", 0, 0, 0, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 32'hDEAD, 32'hBEEF, 1'b1);
    chk("hilo0.whilo_dir", 128'(wb_whilo), 128'(1'b0));
    step("hilo1", 0, 0, 0, 2'b01, 5'd0, 5'd20, 2'b01, 32'h0, 32'h55, 32'hCAFE, 32'hF00D, 1'b1);
    chk("hilo1.whilo_dir", 128'(wb_whilo), 128'(1'b1));

    // Mid-run asynchronous reset while both lanes are writing.
    step("prerst", 0, 0, 0, 2'b11, 5'd5, 5'd3, 2'b11, 32'hAA, 32'hBB, 32'h1, 32'h2, 1'b1);
    chk("prerst.wreg_dir", 128'(wb_wreg), 128'(2'b11));
    #1 rst = 1'b0;
    #1;
    check_all("arst", zero_e);
    model = zero_e;
    sb.delete();
    @(posedge clk);
    #1;
    check_all("arst_hold", zero_e);
    rst = 1'b1;
    step("post", 0, 0, 0, 2'b10, 5'd21, 5'd22, 2'b10, 32'h123, 32'h456, 32'h0, 32'h0, 1'b0);
    chk("post.cnt_dir", 128'(retire_cnt), 128'(4'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
